// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller.
//   ctrl_state_t : controller FSM state encoding (also driven on ctrl_state)
//   REG_ZERO     : architectural zero register, never a real dependency
//   PERF_CNT_W   : width of the optional performance counters
//   sat_inc      : saturating increment used by the performance counters
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH2     = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         PERF_CNT_W = 16;

    // Holds at all-ones instead of wrapping.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        logic [PERF_CNT_W-1:0] one;
        one = {{(PERF_CNT_W-1){1'b0}}, 1'b1};
        return (&value) ? value : value + one;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Combinational load-use hazard compare between the load in EX and the
// instruction in ID.
// Ports:
//   ex_mem_ren  in  1  EX instruction is a load
//   ex_rt       in  5  load destination register
//   id_rs/id_rt in  5  ID source registers
//   id_uses_rt  in  1  ID instruction actually reads rt
//   hazard      out 1  ID must wait one cycle for the load data
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_ren,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       hazard
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    // rt is only a dependency when the ID instruction reads it as a source.
    assign rt_match = id_uses_rt & (ex_rt == id_rt);
    // A load into the zero register produces no value anyone can depend on.
    assign hazard   = ex_mem_ren & (ex_rt != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall / flush / bubble controller for a 5-stage pipeline.
// Event priority: memory wait > taken branch > load-use hazard.
//
// Ports:
//   clock, reset              in   rising-edge clock, async active-high reset
//   id_rs, id_rt, id_uses_rt  in   ID source operands
//   ex_rt, ex_mem_ren         in   EX load destination / load flag
//   ex_branch_taken           in   taken branch/jump resolved in EX
//   mem_req, mem_ready        in   MEM access request / data memory done
//   pc_en .. mem_wb_en        out  PC and pipeline register load enables
//   if_id_flush, id_ex_flush  out  load a NOP into IF/ID, ID/EX
//   mem_wb_bubble             out  load a bubble into MEM/WB
//   ctrl_state                out  RUN=0, LOAD_STALL=1, FLUSH2=2, MEM_WAIT=3
//
// Optional feature (macro PIPE_CTRL_PERF_EN): adds saturating counters
//   stall_cycles, flush_events, wait_cycles (PERF_CNT_W bits each).
// -----------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rt,
    input  logic        ex_mem_ren,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mem_wb_bubble,
    output logic [1:0]  ctrl_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] flush_events,
    output logic [PERF_CNT_W-1:0] wait_cycles
`endif
);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;
    // Set when a memory wait interrupts FLUSH2: the second IF/ID flush is
    // still owed and must be delivered on the release cycle.
    logic        flush_pending_reg;
    logic        flush_pending_next;

    ctrl_state_t eff_state;
    logic        eff_pending;
    logic        mem_wait;
    logic        hazard;

    load_use_detect u_load_use_detect (
        .ex_mem_ren (ex_mem_ren),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hazard     (hazard)
    );

    assign mem_wait = mem_req & ~mem_ready;

    // While reset is held the outputs are the RUN decode of the live inputs.
    assign eff_state   = reset ? ST_RUN : state_reg;
    assign eff_pending = ~reset & flush_pending_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= ST_RUN;
            flush_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            flush_pending_reg <= flush_pending_next;
        end
    end

    always_comb begin
        pc_en              = 1'b1;
        if_id_en           = 1'b1;
        id_ex_en           = 1'b1;
        ex_mem_en          = 1'b1;
        mem_wb_en          = 1'b1;
        if_id_flush        = 1'b0;
        id_ex_flush        = 1'b0;
        mem_wb_bubble      = 1'b0;
        state_next         = ST_RUN;
        flush_pending_next = 1'b0;

        if (mem_wait) begin
            // Freeze the whole pipe; MEM/WB receives a bubble so the frozen
            // MEM instruction is not retired twice.
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_en     = 1'b0;
            mem_wb_en     = 1'b0;
            mem_wb_bubble = 1'b1;
            state_next    = ST_MEM_WAIT;
            flush_pending_next = (eff_state == ST_FLUSH2) |
                                 ((eff_state == ST_MEM_WAIT) & eff_pending);
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_next  = ST_FLUSH2;
        end else begin
            unique case (eff_state)
                ST_RUN: begin
                    if (hazard) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_next  = ST_LOAD_STALL;
                    end
                end
                ST_LOAD_STALL: begin
                    // Hazard masked: the load has now advanced past EX.
                end
                ST_FLUSH2: begin
                    // Second flush covers the synchronous I-mem fetch that
                    // was already in flight when the branch resolved.
                    if_id_flush = 1'b1;
                end
                ST_MEM_WAIT: begin
                    if (eff_pending) begin
                        if_id_flush = 1'b1;
                    end else if (hazard) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                        state_next  = ST_LOAD_STALL;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ctrl_state = state_reg;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_event;
    logic flush_event;
    logic wait_event;

    // A load-use stall is the only decode with pc_en low and id_ex_flush high.
    assign stall_event = ~pc_en & id_ex_flush;
    assign flush_event = ~mem_wait & ex_branch_taken;
    assign wait_event  = mem_wait;

    logic [PERF_CNT_W-1:0] stall_cycles_reg;
    logic [PERF_CNT_W-1:0] flush_events_reg;
    logic [PERF_CNT_W-1:0] wait_cycles_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles_reg <= '0;
            flush_events_reg <= '0;
            wait_cycles_reg  <= '0;
        end else begin
            if (stall_event) stall_cycles_reg <= sat_inc(stall_cycles_reg);
            if (flush_event) flush_events_reg <= sat_inc(flush_events_reg);
            if (wait_event)  wait_cycles_reg  <= sat_inc(wait_cycles_reg);
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_events = flush_events_reg;
    assign wait_cycles  = wait_cycles_reg;
`endif

endmodule
